// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-arbiter definitions: requester IDs, port/requester counts,
// datapath widths and the writeback payload layout.
package wb_arbiter_pkg;

  localparam int unsigned NUM_REQ   = 3;
  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned PREG_W    = 7;
  localparam int unsigned ROB_IDX_W = 6;
  localparam int unsigned XLEN      = 64;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MDU = 2'd1,
    REQ_LSU = 2'd2
  } req_id_e;

  typedef struct packed {
    logic                 need_to_wb;
    logic [PREG_W-1:0]    prd;
    logic [XLEN-1:0]      result;
    logic                 robidx_flag;
    logic [ROB_IDX_W-1:0] robidx;
  } wb_payload_t;

endpackage

// File: rtl/rob_age_cmp.sv
// ROB age compare: flags cmp_* as younger than the reference point, taking the
// wrap flag into account. Shared with the issue queue and LSU.
module rob_age_cmp
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned IDX_W = ROB_IDX_W
) (
  input  logic             ref_flag,
  input  logic [IDX_W-1:0] ref_idx,
  input  logic             cmp_flag,
  input  logic [IDX_W-1:0] cmp_idx,
  output logic             younger_c
);

  assign younger_c = (ref_flag ^ cmp_flag) ^ (ref_idx < cmp_idx);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: up to two of {alu, mdu, lsu} per cycle onto two registered
// writeback ports; lsu has fixed priority, alu/mdu share a round-robin pointer.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,

  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic                 alu_need_to_wb,
  input  logic [PREG_W-1:0]    alu_prd,
  input  logic [XLEN-1:0]      alu_result,
  input  logic                 alu_robidx_flag,
  input  logic [ROB_IDX_W-1:0] alu_robidx,

  input  logic                 mdu_valid,
  output logic                 mdu_ready,
  input  logic                 mdu_need_to_wb,
  input  logic [PREG_W-1:0]    mdu_prd,
  input  logic [XLEN-1:0]      mdu_result,
  input  logic                 mdu_robidx_flag,
  input  logic [ROB_IDX_W-1:0] mdu_robidx,

  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic                 lsu_need_to_wb,
  input  logic [PREG_W-1:0]    lsu_prd,
  input  logic [XLEN-1:0]      lsu_result,
  input  logic                 lsu_robidx_flag,
  input  logic [ROB_IDX_W-1:0] lsu_robidx,

  output logic                 writeback0_valid,
  output logic                 writeback0_need_to_wb,
  output logic [PREG_W-1:0]    writeback0_prd,
  output logic [XLEN-1:0]      writeback0_result,
  output logic                 writeback0_robidx_flag,
  output logic [ROB_IDX_W-1:0] writeback0_robidx,

  output logic                 writeback1_valid,
  output logic                 writeback1_need_to_wb,
  output logic [PREG_W-1:0]    writeback1_prd,
  output logic [XLEN-1:0]      writeback1_result,
  output logic                 writeback1_robidx_flag,
  output logic [ROB_IDX_W-1:0] writeback1_robidx,

  input  logic                 flush_valid,
  input  logic                 flush_robidx_flag,
  input  logic [ROB_IDX_W-1:0] flush_robidx
);

  wb_payload_t            req_pl [NUM_REQ];
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     younger_c;
  logic [NUM_REQ-1:0]     kill_c;
  logic [NUM_REQ-1:0]     grant_c;

  logic                   rr_ptr_q, rr_ptr_d;
  logic                   contend_c;
  req_id_e                order_c    [NUM_REQ];
  req_id_e                port_sel_c [NUM_PORTS];
  logic [NUM_PORTS-1:0]   port_valid_d;
  logic [1:0]             fill_c;

  logic [NUM_PORTS-1:0]   port_valid_q;
  wb_payload_t            port_pl_q  [NUM_PORTS];

  assign req_valid = {lsu_valid, mdu_valid, alu_valid};
  assign req_pl[REQ_ALU] = {alu_need_to_wb, alu_prd, alu_result, alu_robidx_flag, alu_robidx};
  assign req_pl[REQ_MDU] = {mdu_need_to_wb, mdu_prd, mdu_result, mdu_robidx_flag, mdu_robidx};
  assign req_pl[REQ_LSU] = {lsu_need_to_wb, lsu_prd, lsu_result, lsu_robidx_flag, lsu_robidx};

  // Per-requester flush kill
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
    rob_age_cmp #(.IDX_W(ROB_IDX_W)) u_age (
      .ref_flag  (flush_robidx_flag),
      .ref_idx   (flush_robidx),
      .cmp_flag  (req_pl[i].robidx_flag),
      .cmp_idx   (req_pl[i].robidx),
      .younger_c (younger_c[i])
    );
  end

  assign kill_c = {NUM_REQ{flush_valid}} & younger_c;

  // Grant selection and compaction of surviving grants onto ports in grant order
  always_comb begin
    grant_c       = '0;
    rr_ptr_d      = rr_ptr_q;
    port_valid_d  = '0;
    port_sel_c    = '{default: REQ_ALU};
    fill_c        = 2'd0;
    contend_c     = req_valid[REQ_LSU] & req_valid[REQ_ALU] & req_valid[REQ_MDU];

    grant_c[REQ_LSU] = req_valid[REQ_LSU];
    grant_c[REQ_ALU] = req_valid[REQ_ALU] & ~(contend_c &  rr_ptr_q);
    grant_c[REQ_MDU] = req_valid[REQ_MDU] & ~(contend_c & ~rr_ptr_q);
    if (contend_c) rr_ptr_d = ~rr_ptr_q;

    order_c[0] = REQ_LSU;
    order_c[1] = rr_ptr_q ? REQ_MDU : REQ_ALU;
    order_c[2] = rr_ptr_q ? REQ_ALU : REQ_MDU;

    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_c[order_c[k]] && !kill_c[order_c[k]]) begin
        if (fill_c == 2'd0) begin
          port_valid_d[0] = 1'b1;
          port_sel_c[0]   = order_c[k];
        end else if (fill_c == 2'd1) begin
          port_valid_d[1] = 1'b1;
          port_sel_c[1]   = order_c[k];
        end
        fill_c = fill_c + 2'd1;
      end
    end
  end

  assign alu_ready = grant_c[REQ_ALU] & reset_n;
  assign mdu_ready = grant_c[REQ_MDU] & reset_n;
  assign lsu_ready = grant_c[REQ_LSU] & reset_n;

  // Port registers; payload only moves on a surviving grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= 1'b0;
      port_valid_q <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) port_pl_q[p] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      port_valid_q <= port_valid_d;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (port_valid_d[p]) port_pl_q[p] <= req_pl[port_sel_c[p]];
      end
    end
  end

  assign writeback0_valid       = port_valid_q[0];
  assign writeback0_need_to_wb  = port_pl_q[0].need_to_wb;
  assign writeback0_prd         = port_pl_q[0].prd;
  assign writeback0_result      = port_pl_q[0].result;
  assign writeback0_robidx_flag = port_pl_q[0].robidx_flag;
  assign writeback0_robidx      = port_pl_q[0].robidx;

  assign writeback1_valid       = port_valid_q[1];
  assign writeback1_need_to_wb  = port_pl_q[1].need_to_wb;
  assign writeback1_prd         = port_pl_q[1].prd;
  assign writeback1_result      = port_pl_q[1].result;
  assign writeback1_robidx_flag = port_pl_q[1].robidx_flag;
  assign writeback1_robidx      = port_pl_q[1].robidx;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned PLW = 1 + PREG_W + XLEN + 1 + ROB_IDX_W;
  typedef logic [PLW-1:0] pl_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic                 r_valid [3];
  logic                 r_ntw   [3];
  logic [PREG_W-1:0]    r_prd   [3];
  logic [XLEN-1:0]      r_res   [3];
  logic                 r_flag  [3];
  logic [ROB_IDX_W-1:0] r_idx   [3];
  logic                 rdy     [3];

  logic                 wb_valid [2];
  logic                 wb_ntw   [2];
  logic [PREG_W-1:0]    wb_prd   [2];
  logic [XLEN-1:0]      wb_res   [2];
  logic                 wb_flag  [2];
  logic [ROB_IDX_W-1:0] wb_idx   [2];

  logic                 flush_valid;
  logic                 flush_flag;
  logic [ROB_IDX_W-1:0] flush_idx;

  wb_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(r_valid[0]), .alu_ready(rdy[0]), .alu_need_to_wb(r_ntw[0]), .alu_prd(r_prd[0]),
    .alu_result(r_res[0]), .alu_robidx_flag(r_flag[0]), .alu_robidx(r_idx[0]),
    .mdu_valid(r_valid[1]), .mdu_ready(rdy[1]), .mdu_need_to_wb(r_ntw[1]), .mdu_prd(r_prd[1]),
    .mdu_result(r_res[1]), .mdu_robidx_flag(r_flag[1]), .mdu_robidx(r_idx[1]),
    .lsu_valid(r_valid[2]), .lsu_ready(rdy[2]), .lsu_need_to_wb(r_ntw[2]), .lsu_prd(r_prd[2]),
    .lsu_result(r_res[2]), .lsu_robidx_flag(r_flag[2]), .lsu_robidx(r_idx[2]),
    .writeback0_valid(wb_valid[0]), .writeback0_need_to_wb(wb_ntw[0]), .writeback0_prd(wb_prd[0]),
    .writeback0_result(wb_res[0]), .writeback0_robidx_flag(wb_flag[0]), .writeback0_robidx(wb_idx[0]),
    .writeback1_valid(wb_valid[1]), .writeback1_need_to_wb(wb_ntw[1]), .writeback1_prd(wb_prd[1]),
    .writeback1_result(wb_res[1]), .writeback1_robidx_flag(wb_flag[1]), .writeback1_robidx(wb_idx[1]),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_flag), .flush_robidx(flush_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input pl_t act, input pl_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pl_t req_pl(input int i);
    return {r_ntw[i], r_prd[i], r_res[i], r_flag[i], r_idx[i]};
  endfunction

  function automatic pl_t port_pl(input int p);
    return {wb_ntw[p], wb_prd[p], wb_res[p], wb_flag[p], wb_idx[p]};
  endfunction

  // Younger than flush point: same lap -> larger index; other lap -> index not above
  function automatic bit younger(input int i);
    if (!flush_valid) return 1'b0;
    if (r_flag[i] == flush_flag) return r_idx[i] > flush_idx;
    return r_idx[i] <= flush_idx;
  endfunction

  // Reference model state
  bit  rr_m;          // 0: alu preferred, 1: mdu preferred
  bit  exp_v  [2];
  pl_t exp_pl [2];
  bit  m_ready[3];
  int  q[$];
  int  s[$];
  bit  g[3];

  always @(negedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) chk1($sformatf("ready%0d_during_reset", i), rdy[i], 1'b0);
      for (int p = 0; p < 2; p++) begin
        chk1($sformatf("wb%0d_valid_during_reset", p), wb_valid[p], 1'b0);
        chkv($sformatf("wb%0d_payload_during_reset", p), port_pl(p), '0);
      end
      rr_m = 1'b0;
      for (int p = 0; p < 2; p++) begin exp_v[p] = 1'b0; exp_pl[p] = '0; end
      for (int i = 0; i < 3; i++) m_ready[i] = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        chk1($sformatf("model_wb%0d_valid", p), wb_valid[p], exp_v[p]);
        chkv($sformatf("model_wb%0d_payload", p), port_pl(p), exp_pl[p]);
      end
      q.delete();
      if (r_valid[2]) q.push_back(2);
      if (r_valid[rr_m ? 1 : 0] && q.size() < 2) q.push_back(rr_m ? 1 : 0);
      if (r_valid[rr_m ? 0 : 1] && q.size() < 2) q.push_back(rr_m ? 0 : 1);
      for (int i = 0; i < 3; i++) g[i] = 1'b0;
      foreach (q[k]) g[q[k]] = 1'b1;
      if (r_valid[0] && r_valid[1]) begin
        if (!g[0]) rr_m = 1'b0;
        else if (!g[1]) rr_m = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        chk1($sformatf("model_ready%0d", i), rdy[i], g[i]);
        m_ready[i] = g[i];
      end
      s.delete();
      foreach (q[k]) if (!younger(q[k])) s.push_back(q[k]);
      for (int p = 0; p < 2; p++) begin
        exp_v[p] = (p < s.size());
        if (exp_v[p]) exp_pl[p] = req_pl(s[p]);
      end
    end
  end

  task automatic idle();
    for (int i = 0; i < 3; i++) r_valid[i] = 1'b0;
    flush_valid = 1'b0;
    flush_flag  = 1'b0;
    flush_idx   = '0;
  endtask

  task automatic set_req(input int i, input int prd, input logic [XLEN-1:0] res,
                         input bit flag, input int idx);
    r_valid[i] = 1'b1;
    r_ntw[i]   = 1'b1;
    r_prd[i]   = PREG_W'(prd);
    r_res[i]   = res;
    r_flag[i]  = flag;
    r_idx[i]   = ROB_IDX_W'(idx);
  endtask

  task automatic next_drive();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      r_ntw[i] = 1'b0; r_prd[i] = '0; r_res[i] = '0; r_flag[i] = 1'b0; r_idx[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Single alu result
    set_req(0, 5, 64'hAA, 1'b0, 0);
    @(negedge clock);
    chk1("s025_alu_ready", rdy[0], 1'b1);
    chk1("s025_mdu_ready", rdy[1], 1'b0);
    chk1("s025_lsu_ready", rdy[2], 1'b0);
    next_drive(); idle();
    @(negedge clock);
    chk1("s025_wb0_valid", wb_valid[0], 1'b1);
    chkv("s025_wb0_prd", pl_t'(wb_prd[0]), pl_t'(5));
    chkv("s025_wb0_result", pl_t'(wb_res[0]), pl_t'(64'hAA));
    chk1("s025_wb1_valid", wb_valid[1], 1'b0);

    // Three-way contention, rr at alu
    next_drive();
    set_req(2, 1, 64'h11, 1'b0, 1); set_req(0, 2, 64'h22, 1'b0, 2); set_req(1, 3, 64'h33, 1'b0, 3);
    @(negedge clock);
    chk1("s026_lsu_ready", rdy[2], 1'b1);
    chk1("s026_alu_ready", rdy[0], 1'b1);
    chk1("s026_mdu_ready", rdy[1], 1'b0);
    next_drive();
    set_req(2, 4, 64'h44, 1'b0, 4); set_req(0, 6, 64'h66, 1'b0, 6);
    @(negedge clock);
    chkv("s026_wb0_prd_lsu", pl_t'(wb_prd[0]), pl_t'(1));
    chkv("s026_wb1_prd_alu", pl_t'(wb_prd[1]), pl_t'(2));
    chk1("s026_wb1_valid", wb_valid[1], 1'b1);
    chk1("s026b_mdu_ready", rdy[1], 1'b1);
    chk1("s026b_alu_ready", rdy[0], 1'b0);
    next_drive();
    r_valid[2] = 1'b0; r_valid[1] = 1'b0;
    @(negedge clock);
    chkv("s026b_wb0_prd_lsu", pl_t'(wb_prd[0]), pl_t'(4));
    chkv("s026b_wb1_prd_mdu", pl_t'(wb_prd[1]), pl_t'(3));
    chk1("s026c_alu_ready", rdy[0], 1'b1);
    next_drive(); idle();
    @(negedge clock);
    chkv("s026c_wb0_prd_alu", pl_t'(wb_prd[0]), pl_t'(6));
    chk1("s026c_wb1_valid", wb_valid[1], 1'b0);

    // alu and mdu only: both granted, rr winner (alu) on port 0
    next_drive();
    set_req(0, 7, 64'h77, 1'b0, 7); set_req(1, 8, 64'h88, 1'b0, 8);
    @(negedge clock);
    chk1("s027_alu_ready", rdy[0], 1'b1);
    chk1("s027_mdu_ready", rdy[1], 1'b1);
    next_drive(); idle();
    @(negedge clock);
    chkv("s027_wb0_prd_alu", pl_t'(wb_prd[0]), pl_t'(7));
    chkv("s027_wb1_prd_mdu", pl_t'(wb_prd[1]), pl_t'(8));

    // Flush kills alu (idx 12 > 10), mdu (idx 8) compacts to port 0
    next_drive();
    flush_valid = 1'b1; flush_flag = 1'b0; flush_idx = ROB_IDX_W'(10);
    set_req(0, 9, 64'h99, 1'b0, 12); set_req(1, 10, 64'hA0, 1'b0, 8);
    @(negedge clock);
    chk1("s028_alu_ready", rdy[0], 1'b1);
    chk1("s028_mdu_ready", rdy[1], 1'b1);
    next_drive(); idle();
    @(negedge clock);
    chk1("s028_wb0_valid", wb_valid[0], 1'b1);
    chkv("s028_wb0_prd_mdu", pl_t'(wb_prd[0]), pl_t'(10));
    chk1("s028_wb1_valid", wb_valid[1], 1'b0);

    // Flush across the wrap kills lsu
    next_drive();
    flush_valid = 1'b1; flush_flag = 1'b0; flush_idx = ROB_IDX_W'(60);
    set_req(2, 11, 64'hB0, 1'b1, 2);
    @(negedge clock);
    chk1("s029_lsu_ready", rdy[2], 1'b1);
    next_drive(); idle();
    @(negedge clock);
    chk1("s029_wb0_valid", wb_valid[0], 1'b0);
    chk1("s029_wb1_valid", wb_valid[1], 1'b0);
    chkv("s029_wb0_prd_held", pl_t'(wb_prd[0]), pl_t'(10));

    // Move rr to mdu, then reset mid-cycle with a valid result registered
    next_drive();
    set_req(2, 20, 64'h1, 1'b0, 1); set_req(0, 21, 64'h2, 1'b0, 2); set_req(1, 22, 64'h3, 1'b0, 3);
    next_drive();
    r_valid[0] = 1'b0; set_req(2, 23, 64'h4, 1'b0, 4);
    next_drive(); idle();
    set_req(0, 12, 64'hC0, 1'b0, 5);
    next_drive(); idle();
    @(negedge clock);
    chk1("s030_wb0_valid_before", wb_valid[0], 1'b1);
    chkv("s030_wb0_prd_before", pl_t'(wb_prd[0]), pl_t'(12));
    #2;
    set_req(2, 30, 64'h5, 1'b0, 1); set_req(0, 31, 64'h6, 1'b0, 2); set_req(1, 32, 64'h7, 1'b0, 3);
    reset_n = 1'b0;
    #1;
    chk1("s030_wb0_valid_async", wb_valid[0], 1'b0);
    chkv("s030_wb0_prd_async", pl_t'(wb_prd[0]), pl_t'(0));
    chk1("s030_alu_ready_rst", rdy[0], 1'b0);
    chk1("s030_lsu_ready_rst", rdy[2], 1'b0);
    next_drive();
    next_drive();
    reset_n = 1'b1;
    @(negedge clock);
    chk1("s030_alu_ready_after", rdy[0], 1'b1);
    chk1("s030_mdu_ready_after", rdy[1], 1'b0);
    chk1("s030_lsu_ready_after", rdy[2], 1'b1);

    // Randomized traffic; requesters hold until accepted
    for (int cyc = 0; cyc < 4000; cyc++) begin
      next_drive();
      reset_n = ((cyc % 700) == 350) ? 1'b0 : 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (!r_valid[i] || m_ready[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            r_valid[i] = 1'b1;
            r_ntw[i]   = 1'($urandom);
            r_prd[i]   = PREG_W'($urandom);
            r_res[i]   = {$urandom, $urandom};
            r_flag[i]  = 1'($urandom);
            r_idx[i]   = ROB_IDX_W'($urandom);
          end else begin
            r_valid[i] = 1'b0;
          end
        end
      end
      flush_valid = ($urandom_range(0, 3) == 0);
      flush_flag  = 1'($urandom);
      flush_idx   = ROB_IDX_W'($urandom);
    end
    next_drive();
    reset_n = 1'b1;
    idle();
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
